// File: rtl/powlib_ffsync_ctrl.sv
// Source-side controller for a toggle-handshake data synchronizer: holds a word,
// waits a setup time, toggles req and waits for the far side to echo it on ack.
module powlib_ffsync_ctrl #(
    parameter int unsigned    W    = 8,
    parameter logic [W-1:0]   INIT = '0,
    parameter int unsigned    SU   = 1,
    parameter int unsigned    TO   = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_d,
    input  logic         in_vld,
    output logic         in_rdy,
    output logic [W-1:0] out_d,
    output logic         req,
    input  logic         ack,
    output logic         done,
    output logic         err
);

    localparam int unsigned CMAX = (SU > TO) ? ((SU > 2) ? SU : 2)
                                             : ((TO > 2) ? TO : 2);
    localparam int unsigned CW   = $clog2(CMAX);

    localparam logic [CW-1:0] SU_LAST = CW'(SU - 1);
    localparam logic [CW-1:0] TO_LAST = CW'((TO != 0) ? TO - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        WAIT  = 2'd2,
        ERR   = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   su_cnt;
    logic [CW-1:0]   to_cnt;

    logic            accept;
    logic            toggle;
    logic            ack_hit;
    logic            to_fire;

    assign in_rdy = (state == IDLE);

    // NOTE: every signal gets a default before the case, so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        toggle     = 1'b0;
        ack_hit    = 1'b0;
        to_fire    = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_vld) begin
                    accept     = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                if (su_cnt == SU_LAST) begin
                    toggle     = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                // A matching ack beats a timeout landing on the same edge.
                if (ack == req) begin
                    ack_hit    = 1'b1;
                    state_next = IDLE;
                end else if ((TO != 0) && (to_cnt == TO_LAST)) begin
                    to_fire    = 1'b1;
                    state_next = ERR;
                end
            end
            ERR: begin
                state_next = ERR;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_d  <= INIT;
            req    <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            su_cnt <= '0;
            to_cnt <= '0;
        end else begin
            done <= ack_hit;
            if (to_fire) begin
                err <= 1'b1;
            end
            if (accept) begin
                out_d  <= in_d;
                su_cnt <= '0;
            end else if ((state == SETUP) && !toggle) begin
                su_cnt <= su_cnt + CW'(1);
            end
            // Counters stop at their terminal value instead of wrapping.
            if (toggle) begin
                req    <= ~req;
                to_cnt <= '0;
            end else if ((TO != 0) && (state == WAIT) && (ack != req) && !to_fire) begin
                to_cnt <= to_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_powlib_ffsync_ctrl.sv
// Bench for powlib_ffsync_ctrl: two configurations run side by side against a
// transaction-timestamp reference model, with directed scenarios then random traffic.
module tb_powlib_ffsync_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_d;
    logic       in_vld;
    logic       ack_a, ack_b;

    logic       in_rdy_a, req_a, done_a, err_a;
    logic [7:0] out_d_a;
    logic       in_rdy_b, req_b, done_b, err_b;
    logic [7:0] out_d_b;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    powlib_ffsync_ctrl #(.W(8), .INIT(8'h00), .SU(1), .TO(0)) dut_a (
        .clk(clk), .rst(rst), .in_d(in_d), .in_vld(in_vld), .in_rdy(in_rdy_a),
        .out_d(out_d_a), .req(req_a), .ack(ack_a), .done(done_a), .err(err_a)
    );

    powlib_ffsync_ctrl #(.W(8), .INIT(8'h3C), .SU(4), .TO(8)) dut_b (
        .clk(clk), .rst(rst), .in_d(in_d), .in_vld(in_vld), .in_rdy(in_rdy_b),
        .out_d(out_d_b), .req(req_b), .ack(ack_b), .done(done_b), .err(err_b)
    );

    // Model: a transfer is remembered by the edge it was accepted on; the req
    // toggle is SU edges later and the timeout TO edges after that.
    typedef struct {
        bit         busy;
        bit         locked;
        bit         req;
        bit         done;
        logic [7:0] data;
        int         t_acc;
    } mdl_t;

    mdl_t ma = '{0, 0, 0, 0, 8'h00, 0};
    mdl_t mb = '{0, 0, 0, 0, 8'h3C, 0};

    function automatic mdl_t step(input mdl_t m, input int n, input bit rst_i,
                                  input bit vld, input logic [7:0] d, input bit ack_i,
                                  input int su, input int to, input logic [7:0] init);
        mdl_t r;
        r      = m;
        r.done = 1'b0;
        if (rst_i) begin
            r.busy   = 1'b0;
            r.locked = 1'b0;
            r.req    = 1'b0;
            r.data   = init;
            r.t_acc  = 0;
        end else if (r.locked) begin
            r.locked = 1'b1;
        end else if (!r.busy) begin
            if (vld) begin
                r.busy  = 1'b1;
                r.data  = d;
                r.t_acc = n;
            end
        end else begin
            int age;
            age = n - r.t_acc;
            if (age == su) begin
                r.req = ~r.req;
            end else if (age > su) begin
                if (ack_i == r.req) begin
                    r.busy = 1'b0;
                    r.done = 1'b1;
                end else if ((to > 0) && (age - su == to)) begin
                    r.locked = 1'b1;
                end
            end
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // One clock edge: advance both models on the inputs the DUTs just sampled,
    // then compare every output 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        ma = step(ma, cyc, rst, in_vld, in_d, ack_a, 1, 0, 8'h00);
        mb = step(mb, cyc, rst, in_vld, in_d, ack_b, 4, 8, 8'h3C);
        check("a_rdy",  32'(in_rdy_a), 32'(!ma.busy && !ma.locked));
        check("a_out",  32'(out_d_a),  32'(ma.data));
        check("a_req",  32'(req_a),    32'(ma.req));
        check("a_done", 32'(done_a),   32'(ma.done));
        check("a_err",  32'(err_a),    32'(ma.locked));
        check("b_rdy",  32'(in_rdy_b), 32'(!mb.busy && !mb.locked));
        check("b_out",  32'(out_d_b),  32'(mb.data));
        check("b_req",  32'(req_b),    32'(mb.req));
        check("b_done", 32'(done_b),   32'(mb.done));
        check("b_err",  32'(err_b),    32'(mb.locked));
        cyc++;
    endtask

    initial begin
        rst    = 1'b1;
        in_vld = 1'b0;
        in_d   = 8'h00;
        ack_a  = 1'b0;
        ack_b  = 1'b0;
        tick();
        tick();
        check("rst_out_b", 32'(out_d_b), 32'h3C);
        check("rst_rdy_a", 32'(in_rdy_a), 32'd1);
        check("rst_req_a", 32'(req_a), 32'd0);
        rst = 1'b0;

        // Single transfer on A (SU=1) alongside setup timing on B (SU=4).
        in_vld = 1'b1;
        in_d   = 8'hA5;
        tick();                                    // edge 0: accept
        check("s1_out_a", 32'(out_d_a), 32'hA5);
        check("s1_rdy_a", 32'(in_rdy_a), 32'd0);
        in_vld = 1'b0;
        in_d   = 8'h11;
        tick();                                    // edge 1
        check("s1_req_a", 32'(req_a), 32'd1);
        check("s2_req_b_e1", 32'(req_b), 32'd0);
        tick();
        tick();                                    // edges 2,3
        check("s2_req_b_e3", 32'(req_b), 32'd0);
        check("s2_out_b_e3", 32'(out_d_b), 32'hA5);
        ack_a = 1'b1;
        tick();                                    // edge 4
        check("s1_done_a", 32'(done_a), 32'd1);
        check("s1_rdy_done_a", 32'(in_rdy_a), 32'd1);
        check("s2_req_b_e4", 32'(req_b), 32'd1);
        check("s2_out_b_e4", 32'(out_d_b), 32'hA5);

        // B never sees ack: timeout on the 8th WAIT edge (edge 12).
        repeat (7) tick();                         // edges 5..11
        check("s3_err_b_e11", 32'(err_b), 32'd0);
        tick();                                    // edge 12
        check("s3_err_b", 32'(err_b), 32'd1);
        check("s3_rdy_b", 32'(in_rdy_b), 32'd0);
        in_vld = 1'b1;
        in_d   = 8'h77;
        repeat (3) tick();
        in_vld = 1'b0;
        check("s3_hold_out_b", 32'(out_d_b), 32'hA5);
        check("s3_hold_err_b", 32'(err_b), 32'd1);

        rst   = 1'b1;
        ack_a = 1'b0;
        ack_b = 1'b0;
        tick();
        rst = 1'b0;
        check("s3_clr_err_b", 32'(err_b), 32'd0);

        // Reset in the middle of WAIT on B.
        in_vld = 1'b1;
        in_d   = 8'hC3;
        tick();                                    // edge 0
        in_vld = 1'b0;
        repeat (6) tick();                         // WAIT from edge 4
        check("s4_req_b_pre", 32'(req_b), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("s4_out_b", 32'(out_d_b), 32'h3C);
        check("s4_req_b", 32'(req_b), 32'd0);
        check("s4_err_b", 32'(err_b), 32'd0);
        check("s4_rdy_b", 32'(in_rdy_b), 32'd1);

        // Timeout race on B: ack matches exactly on the timeout edge.
        in_vld = 1'b1;
        in_d   = 8'h99;
        tick();                                    // edge 0
        in_vld = 1'b0;
        repeat (11) tick();                        // edges 1..11
        ack_b = 1'b1;
        ack_a = 1'b1;
        tick();                                    // edge 12
        check("s5_done_b", 32'(done_b), 32'd1);
        check("s5_err_b", 32'(err_b), 32'd0);
        check("s5_rdy_b", 32'(in_rdy_b), 32'd1);

        // Back-to-back on A with in_vld held; ack echoes req 3 cycles later.
        in_vld = 1'b1;
        in_d   = 8'h01;
        tick();                                    // edge 0: accept 0x01
        check("s6_out1_a", 32'(out_d_a), 32'h01);
        in_d = 8'h02;
        tick();                                    // edge 1: req 1->0
        check("s6_req1_a", 32'(req_a), 32'd0);
        tick();
        tick();
        ack_a = 1'b0;
        tick();                                    // edge 4: ack seen
        check("s6_done1_a", 32'(done_a), 32'd1);
        tick();                                    // edge 5: accept 0x02
        check("s6_out2_a", 32'(out_d_a), 32'h02);
        in_vld = 1'b0;
        tick();                                    // edge 6: req 0->1
        check("s6_req2_a", 32'(req_a), 32'd1);
        tick();
        tick();
        ack_a = 1'b1;
        tick();                                    // edge 9
        check("s6_done2_a", 32'(done_a), 32'd1);

        // Random traffic: noisy ack, random valid/data, occasional reset.
        rst   = 1'b1;
        ack_a = 1'b0;
        ack_b = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            rst    = ($urandom_range(0, 99) == 0);
            in_vld = 1'($urandom_range(0, 1));
            in_d   = 8'($urandom);
            if (rst) begin
                ack_a = 1'b0;
                ack_b = 1'b0;
            end else begin
                if ($urandom_range(0, 15) == 0)                    ack_a = ~ack_a;
                else if (ack_a != req_a && $urandom_range(0, 2) == 0) ack_a = req_a;
                if ($urandom_range(0, 15) == 0)                    ack_b = ~ack_b;
                else if (ack_b != req_b && $urandom_range(0, 2) == 0) ack_b = req_b;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
